// File: rtl/xosera_bus_pkg.sv
// Shared constants for the Xosera host bus controller: FSM encodings, bus pin
// polarities and the legal synchronizer depth range.
package xosera_bus_pkg;
  typedef logic [1:0] bus_state_t;

  localparam bus_state_t ST_IDLE   = 2'd0;
  localparam bus_state_t ST_RD_REQ = 2'd1;
  localparam bus_state_t ST_RD_CAP = 2'd2;
  localparam bus_state_t ST_HOLD   = 2'd3;

  localparam logic CS_ENABLED = 1'b0;
  localparam logic RNW_READ   = 1'b1;
  localparam logic BYTE_EVEN  = 1'b0;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 3;
endpackage

// File: rtl/xosera_bus_sync.sv
// Single-bit N-stage synchronizer with a parameterized reset value, so the
// inactive level of each bus pin is what the core sees out of reset.
module xosera_bus_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= {STAGES{RST_VAL}};
    else            sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/xosera_bus_ctrl.sv
// Host bus sequencer: synchronizes the 8-bit bus, merges even/odd byte writes
// into 16-bit register writes and fetches read words with an atomic odd byte.
module xosera_bus_ctrl
  import xosera_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REG_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset_n_i,
  input  logic                bus_cs_n_i,
  input  logic                bus_rd_nwr_i,
  input  logic                bus_bytesel_i,
  input  logic [REG_BITS-1:0] bus_reg_num_i,
  input  logic [7:0]          bus_data_i,
  output logic [7:0]          bus_data_o,
  output logic                reg_rd_req_o,
  output logic [REG_BITS-1:0] reg_rd_num_o,
  input  logic [15:0]         reg_rd_data_i,
  output logic                reg_wr_valid_o,
  input  logic                reg_wr_ready_i,
  output logic [REG_BITS-1:0] reg_wr_num_o,
  output logic [15:0]         reg_wr_data_o,
  output logic                overflow_o
);
  localparam int IN_W = 3 + REG_BITS + 8;

  logic [IN_W-1:0] pin_raw, pin_sync;

  // bit 0 is cs_n, the only pin whose idle level is 1
  assign pin_raw = {bus_data_i, bus_reg_num_i, bus_bytesel_i, bus_rd_nwr_i, bus_cs_n_i};

  for (genvar i = 0; i < IN_W; i++) begin : g_sync
    xosera_bus_sync #(
      .STAGES (SYNC_STAGES),
      .RST_VAL((i == 0) ? 1'b1 : 1'b0)
    ) u_sync (
      .clk      (clk),
      .reset_n_i(reset_n_i),
      .d_i      (pin_raw[i]),
      .q_o      (pin_sync[i])
    );
  end

  logic                cs_n_s, rnw_s, bsel_s;
  logic [REG_BITS-1:0] reg_s;
  logic [7:0]          data_s;

  assign cs_n_s = pin_sync[0];
  assign rnw_s  = pin_sync[1];
  assign bsel_s = pin_sync[2];
  assign reg_s  = pin_sync[3 +: REG_BITS];
  assign data_s = pin_sync[3+REG_BITS +: 8];

  bus_state_t          state_q, state_d;
  logic                cs_prev_q, cs_prev_d;
  logic                cap_bsel_q, cap_bsel_d;
  logic [REG_BITS-1:0] cap_reg_q, cap_reg_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         latch_q, latch_d;
  logic                latch_vld_q, latch_vld_d;
  logic                latch_even_q, latch_even_d;
  logic [REG_BITS-1:0] latch_reg_q, latch_reg_d;
  logic [7:0]          bus_data_q, bus_data_d;
  logic                wr_vld_q, wr_vld_d;
  logic [REG_BITS-1:0] wr_num_q, wr_num_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                ovf_q, ovf_d;

  logic start, atomic_odd, wr_slot_free;

  assign start        = (cs_n_s == CS_ENABLED) && (cs_prev_q != CS_ENABLED);
  assign atomic_odd   = (bsel_s != BYTE_EVEN) && latch_vld_q && latch_even_q &&
                        (latch_reg_q == reg_s);
  // a slot draining this cycle may take the new odd write in the same cycle
  assign wr_slot_free = !wr_vld_q || reg_wr_ready_i;

  always_comb begin
    state_d      = state_q;
    cs_prev_d    = cs_n_s;
    cap_bsel_d   = cap_bsel_q;
    cap_reg_d    = cap_reg_q;
    hi_d         = hi_q;
    latch_d      = latch_q;
    latch_vld_d  = latch_vld_q;
    latch_even_d = latch_even_q;
    latch_reg_d  = latch_reg_q;
    bus_data_d   = bus_data_q;
    wr_vld_d     = wr_vld_q;
    wr_num_d     = wr_num_q;
    wr_data_d    = wr_data_q;
    ovf_d        = ovf_q;

    if (wr_vld_q && reg_wr_ready_i) wr_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_bsel_d  = bsel_s;
          cap_reg_d   = reg_s;
          latch_vld_d = 1'b0;
          state_d     = ST_HOLD;
          if (rnw_s == RNW_READ) begin
            if (atomic_odd) bus_data_d = latch_q[7:0];
            else            state_d    = ST_RD_REQ;
          end else if (bsel_s == BYTE_EVEN) begin
            hi_d = data_s;
          end else if (wr_slot_free) begin
            wr_vld_d  = 1'b1;
            wr_num_d  = reg_s;
            wr_data_d = {hi_q, data_s};
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        latch_d      = reg_rd_data_i;
        latch_vld_d  = 1'b1;
        latch_even_d = (cap_bsel_q == BYTE_EVEN);
        latch_reg_d  = cap_reg_q;
        bus_data_d   = (cap_bsel_q == BYTE_EVEN) ? reg_rd_data_i[15:8] : reg_rd_data_i[7:0];
        state_d      = ST_HOLD;
      end
      ST_HOLD: if (cs_n_s != CS_ENABLED) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      cs_prev_q    <= 1'b1;
      cap_bsel_q   <= 1'b0;
      cap_reg_q    <= '0;
      hi_q         <= '0;
      latch_q      <= '0;
      latch_vld_q  <= 1'b0;
      latch_even_q <= 1'b0;
      latch_reg_q  <= '0;
      bus_data_q   <= '0;
      wr_vld_q     <= 1'b0;
      wr_num_q     <= '0;
      wr_data_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_prev_q    <= cs_prev_d;
      cap_bsel_q   <= cap_bsel_d;
      cap_reg_q    <= cap_reg_d;
      hi_q         <= hi_d;
      latch_q      <= latch_d;
      latch_vld_q  <= latch_vld_d;
      latch_even_q <= latch_even_d;
      latch_reg_q  <= latch_reg_d;
      bus_data_q   <= bus_data_d;
      wr_vld_q     <= wr_vld_d;
      wr_num_q     <= wr_num_d;
      wr_data_q    <= wr_data_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus_data_o     = bus_data_q;
  assign reg_rd_req_o   = (state_q == ST_RD_REQ);
  assign reg_rd_num_o   = cap_reg_q;
  assign reg_wr_valid_o = wr_vld_q;
  assign reg_wr_num_o   = wr_num_q;
  assign reg_wr_data_o  = wr_data_q;
  assign overflow_o     = ovf_q;
endmodule
